// File: rtl/mips_pkg.sv
// Shared definitions for the fetch unit and the decode/control block.
//   - fetch_state_t : fetch FSM state encoding
//   - RESET_PC_DEFAULT : default PC value loaded on reset
//   - opcode / funct constants used by decode
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] FUNCT_ADD = 6'h20;

endpackage

// File: rtl/next_pc.sv
// Next-PC selection for the fetch unit (purely combinational).
// Ports:
//   pc_plus4  in  ADDR_W  address of the current instruction + 4
//   instr     in  32      current instruction word
//   br        in  1       current instruction is a control transfer
//   j_or_b    in  1       1 = absolute jump, 0 = conditional branch
//   br_taken  in  1       branch condition from the ALU
//   npc       out ADDR_W  selected next PC
module next_pc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [31:0]       instr,
  input  logic              br,
  input  logic              j_or_b,
  input  logic              br_taken,
  output logic [ADDR_W-1:0] npc
);

  logic signed [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0]        w_br_target;
  logic [ADDR_W-1:0]        w_j_target;
  logic                     w_unused;

  // Word offset, sign-extended and scaled to bytes; the add wraps silently.
  assign w_br_off    = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign w_br_target = pc_plus4 + w_br_off;

  // Jump stays inside the 256 MB region of the delay-slot address.
  assign w_j_target  = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};

  // Opcode field is decode's business, not needed for target arithmetic.
  assign w_unused    = &{1'b0, instr[31:26]};

  always_comb begin
    npc = pc_plus4;
    if (br && j_or_b) begin
      npc = w_j_target;
    end else if (br && br_taken) begin
      npc = w_br_target;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, reads one word at a time from
// instruction memory over a req/ack handshake and presents it to decode.
// Ports:
//   clk, rst               clock (rising edge), async active-high reset
//   imem_req/imem_addr     read request and word address (= pc)
//   imem_ack/imem_rdata    read completion and instruction word
//   instr/instr_valid/pc   instruction presented to decode and its address
//   pc_plus4               pc + 4 (wraps)
//   stall                  decode not ready; hold current instruction
//   br/j_or_b/br_taken     control-transfer info, sampled on consume
//   instr_count            instructions consumed since reset (wraps)
module ifetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              stall,
  input  logic              br,
  input  logic              j_or_b,
  input  logic              br_taken,
  output logic [31:0]       instr_count
);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic [31:0]       r_count;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_npc;
  logic              w_fire;
  logic              w_consume;

  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .pc_plus4 (w_pc_plus4),
    .instr    (r_instr),
    .br       (br),
    .j_or_b   (j_or_b),
    .br_taken (br_taken),
    .npc      (w_npc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Outputs decode straight from the state register so reset clears
  // imem_req and instr_valid without waiting for a clock edge.
  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    w_fire       = 1'b0;
    w_consume    = 1'b0;
    case (r_state)
      IDLE: begin
        w_next_state = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        w_fire   = imem_ack;
        if (imem_ack) begin
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        w_consume   = !stall;
        if (!stall) begin
          w_next_state = REQ;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_count <= 32'h0;
    end else begin
      if (w_fire) begin
        r_instr <= imem_rdata;
      end
      if (w_consume) begin
        r_pc    <= w_npc;
        r_count <= r_count + 32'd1;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr       = r_instr;
  assign instr_count = r_count;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        br;
  logic        j_or_b;
  logic        br_taken;
  logic [31:0] instr_count;

  // Second instance with a high reset PC: zero-wait memory returning a jump.
  logic        dj_req;
  logic [31:0] dj_addr;
  logic [31:0] dj_instr;
  logic        dj_valid;
  logic [31:0] dj_pc;
  logic [31:0] dj_pc_plus4;
  logic [31:0] dj_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_count;
  logic [31:0] cur_pc;

  ifetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .stall       (stall),
    .br          (br),
    .j_or_b      (j_or_b),
    .br_taken    (br_taken),
    .instr_count (instr_count)
  );

  ifetch_unit #(
    .RESET_PC(32'h8000_0010)
  ) dut_j (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (dj_req),
    .imem_addr   (dj_addr),
    .imem_ack    (1'b1),
    .imem_rdata  (32'h0800_0040),
    .instr       (dj_instr),
    .instr_valid (dj_valid),
    .pc          (dj_pc),
    .pc_plus4    (dj_pc_plus4),
    .stall       (1'b0),
    .br          (1'b1),
    .j_or_b      (1'b1),
    .br_taken    (1'b0),
    .instr_count (dj_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] word;
    logic        br;
    logic        jb;
    logic        bt;
    int          lat;
    int          stl;
    logic [31:0] exp_next;
  } row_t;

  typedef struct {
    logic        req;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] count;
  } zw_t;

  // One full fetch/consume at cur_pc; ends with the DUT back in REQ.
  task automatic fetch_one(input row_t r, input int idx);
    int n;
    stall = (r.stl > 0);
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk($sformatf("row%0d_req", idx), {31'h0, imem_req}, 32'h1);
    chk($sformatf("row%0d_addr", idx), imem_addr, cur_pc);
    for (int i = 0; i < r.lat; i++) begin
      tick();
      chk($sformatf("row%0d_lat_req", idx), {31'h0, imem_req}, 32'h1);
      chk($sformatf("row%0d_lat_addr", idx), imem_addr, cur_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = r.word;
    br         = r.br;
    j_or_b     = r.jb;
    br_taken   = r.bt;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk($sformatf("row%0d_valid", idx), {31'h0, instr_valid}, 32'h1);
    chk($sformatf("row%0d_instr", idx), instr, r.word);
    chk($sformatf("row%0d_pc", idx), pc, cur_pc);
    chk($sformatf("row%0d_pc4", idx), pc_plus4, cur_pc + 32'd4);
    chk($sformatf("row%0d_count", idx), instr_count, exp_count);
    for (int i = 0; i < r.stl; i++) begin
      imem_ack = 1'b1;   // stray ack while holding must be ignored
      tick();
      chk($sformatf("row%0d_stall_instr", idx), instr, r.word);
      chk($sformatf("row%0d_stall_pc", idx), pc, cur_pc);
      chk($sformatf("row%0d_stall_cnt", idx), instr_count, exp_count);
      chk($sformatf("row%0d_stall_vld", idx), {31'h0, instr_valid}, 32'h1);
    end
    imem_ack = 1'b0;
    stall    = 1'b0;
    tick();
    exp_count = exp_count + 32'd1;
    chk($sformatf("row%0d_next_req", idx), {31'h0, imem_req}, 32'h1);
    chk($sformatf("row%0d_next_addr", idx), imem_addr, r.exp_next);
    chk($sformatf("row%0d_next_vld", idx), {31'h0, instr_valid}, 32'h0);
    chk($sformatf("row%0d_next_cnt", idx), instr_count, exp_count);
    br       = 1'b0;
    j_or_b   = 1'b0;
    br_taken = 1'b0;
    cur_pc   = r.exp_next;
  endtask

  initial begin
    row_t rows[12];
    zw_t  zw[7];
    row_t restart;

    rows[0]  = '{32'h0800_0040, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_0100};
    rows[1]  = '{32'h1C20_FFFE, 1'b1, 1'b0, 1'b1, 1, 0, 32'h0000_00FC};
    rows[2]  = '{32'h0800_0040, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_0100};
    rows[3]  = '{32'h1C20_FFFE, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0000_0104};
    rows[4]  = '{32'h1C20_FFFE, 1'b0, 1'b1, 1'b1, 3, 5, 32'h0000_0108};
    rows[5]  = '{32'h1C00_0003, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0000_0118};
    rows[6]  = '{32'h1C00_FFB9, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0000_0000};
    rows[7]  = '{32'h1C20_FFFE, 1'b1, 1'b0, 1'b1, 0, 0, 32'hFFFF_FFFC};
    rows[8]  = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0000};
    rows[9]  = '{32'h0BFF_FFFF, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0FFF_FFFC};
    rows[10] = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 0, 0, 32'h1000_0000};
    rows[11] = '{32'h0800_0001, 1'b1, 1'b1, 1'b0, 0, 0, 32'h1000_0004};

    zw[0] = '{1'b1, 1'b0, 32'h0, 32'd0};
    zw[1] = '{1'b0, 1'b1, 32'h0, 32'd0};
    zw[2] = '{1'b1, 1'b0, 32'h4, 32'd1};
    zw[3] = '{1'b0, 1'b1, 32'h4, 32'd1};
    zw[4] = '{1'b1, 1'b0, 32'h8, 32'd2};
    zw[5] = '{1'b0, 1'b1, 32'h8, 32'd2};
    zw[6] = '{1'b1, 1'b0, 32'hC, 32'd3};

    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    br         = 1'b0;
    j_or_b     = 1'b0;
    br_taken   = 1'b0;
    tick();
    tick();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_instr", instr, 32'h0);
    chk("rst_count", instr_count, 32'h0);

    // Zero-wait memory, ack tied high.
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0020;
    rst        = 1'b0;
    chk("zw_idle_req", {31'h0, imem_req}, 32'h0);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("zw%0d_req", k), {31'h0, imem_req}, {31'h0, zw[k].req});
      chk($sformatf("zw%0d_valid", k), {31'h0, instr_valid}, {31'h0, zw[k].valid});
      if (zw[k].req) chk($sformatf("zw%0d_addr", k), imem_addr, zw[k].addr);
      chk($sformatf("zw%0d_count", k), instr_count, zw[k].count);
      if (k == 0) chk("jmp_first_addr", dj_addr, 32'h8000_0010);
      if (k == 2) chk("jmp_target_addr", dj_addr, 32'h8000_0100);
      if (k == 2) chk("jmp_req", {31'h0, dj_req}, 32'h1);
    end

    // Restart from reset for the directed control-transfer chain.
    imem_ack = 1'b0;
    rst      = 1'b1;
    tick();
    rst       = 1'b0;
    exp_count = 32'h0;
    cur_pc    = 32'h0;
    for (int i = 0; i < 12; i++) begin
      fetch_one(rows[i], i);
    end

    // Reset while a fetch is outstanding.
    tick();
    tick();
    chk("mid_req_before", {31'h0, imem_req}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_req_async", {31'h0, imem_req}, 32'h0);
    chk("mid_valid_async", {31'h0, instr_valid}, 32'h0);
    chk("mid_pc_async", pc, 32'h0);
    chk("mid_count_async", instr_count, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    tick();
    chk("mid_instr_in_rst", instr, 32'h0);
    rst = 1'b0;
    tick();
    chk("mid_late_ack_instr", instr, 32'h0);
    chk("mid_restart_req", {31'h0, imem_req}, 32'h1);
    chk("mid_restart_addr", imem_addr, 32'h0);
    imem_ack  = 1'b0;
    exp_count = 32'h0;
    cur_pc    = 32'h0;
    restart   = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0004};
    fetch_one(restart, 99);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
